// File: rtl/ula_arb_pkg.sv
// Shared definitions for the ULA arbiter/sequencer: FSM state encoding,
// opcode width and default operand width (shared with the ULA itself).
package ula_arb_pkg;

  localparam int unsigned OP_W  = 3;
  localparam int unsigned W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/ula_arb_rr_arb2.sv
// rr_arb2: combinational 2-way round-robin picker.
//   req0, req1 : pending requests
//   last       : id of the most recent grant
//   win        : chosen requester (0 when no request; caller qualifies)
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic win
);

  always_comb begin
    win = 1'b0;
    if (req0 && req1) begin
      win = ~last;
    end else if (req1) begin
      win = 1'b1;
    end
  end

endmodule

// File: rtl/ula_arb.sv
// ula_arb: two-requester round-robin arbiter and sequencer for the shared ULA.
//   clk, clr               : clock, synchronous active-high reset
//   reqN, aN, bN, opN      : client N request, operands, opcode
//   doneN, rN, fN          : client N completion pulse, result, flag registers
//   busy                   : high whenever the FSM is not in IDLE
//   ula_a, ula_b, ula_op   : registered operands/opcode driven to the ULA
//   ula_s, ula_flag        : ULA result and flag, valid LAT cycles after issue
module ula_arb
  import ula_arb_pkg::*;
#(
  parameter int unsigned W   = W_DEF,
  parameter int unsigned LAT = 1
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            req0,
  input  logic [W-1:0]    a0,
  input  logic [W-1:0]    b0,
  input  logic [OP_W-1:0] op0,
  input  logic            req1,
  input  logic [W-1:0]    a1,
  input  logic [W-1:0]    b1,
  input  logic [OP_W-1:0] op1,
  output logic            done0,
  output logic            done1,
  output logic [W-1:0]    r0,
  output logic [W-1:0]    r1,
  output logic            f0,
  output logic            f1,
  output logic            busy,
  output logic [W-1:0]    ula_a,
  output logic [W-1:0]    ula_b,
  output logic [OP_W-1:0] ula_op,
  input  logic [W-1:0]    ula_s,
  input  logic            ula_flag
);

  // WAIT lasts LAT cycles: counter starts at LAT-1 and capture happens at 0.
  localparam logic [2:0] CNT_INIT = (LAT != 0) ? 3'(LAT - 1) : 3'd0;

  state_e            st_q, st_d;
  logic              last_q, last_d;
  logic              win_q, win_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;
  logic [W-1:0]      r0_q, r0_d;
  logic [W-1:0]      r1_q, r1_d;
  logic              f0_q, f0_d;
  logic              f1_q, f1_d;
  logic [W-1:0]      ula_a_q, ula_a_d;
  logic [W-1:0]      ula_b_q, ula_b_d;
  logic [OP_W-1:0]   ula_op_q, ula_op_d;
  logic              win;
  logic              cap;

  rr_arb2 u_rr (
    .req0 (req0),
    .req1 (req1),
    .last (last_q),
    .win  (win)
  );

  always_comb begin
    st_d     = st_q;
    last_d   = last_q;
    win_d    = win_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    r0_d     = r0_q;
    r1_d     = r1_q;
    f0_d     = f0_q;
    f1_d     = f1_q;
    ula_a_d  = ula_a_q;
    ula_b_d  = ula_b_q;
    ula_op_d = ula_op_q;
    cap      = 1'b0;

    unique case (st_q)
      IDLE: begin
        if (req0 || req1) begin
          st_d     = ISSUE;
          busy_d   = 1'b1;
          win_d    = win;
          last_d   = win;
          ula_a_d  = win ? a1  : a0;
          ula_b_d  = win ? b1  : b0;
          ula_op_d = win ? op1 : op0;
        end
      end
      ISSUE: begin
        if (LAT != 0) begin
          st_d  = WAIT;
          cnt_d = CNT_INIT;
        end else begin
          cap = 1'b1;
        end
      end
      WAIT: begin
        if (cnt_q == 3'd0) begin
          cap = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      DONE: begin
        st_d   = IDLE;
        busy_d = 1'b0;
      end
    endcase

    // Capture lands in the winner's registers only; done pulses in DONE.
    if (cap) begin
      st_d = DONE;
      if (win_q) begin
        r1_d    = ula_s;
        f1_d    = ula_flag;
        done1_d = 1'b1;
      end else begin
        r0_d    = ula_s;
        f0_d    = ula_flag;
        done0_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      st_q     <= IDLE;
      last_q   <= 1'b1;
      win_q    <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      r0_q     <= '0;
      r1_q     <= '0;
      f0_q     <= 1'b0;
      f1_q     <= 1'b0;
      ula_a_q  <= '0;
      ula_b_q  <= '0;
      ula_op_q <= '0;
    end else begin
      st_q     <= st_d;
      last_q   <= last_d;
      win_q    <= win_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      r0_q     <= r0_d;
      r1_q     <= r1_d;
      f0_q     <= f0_d;
      f1_q     <= f1_d;
      ula_a_q  <= ula_a_d;
      ula_b_q  <= ula_b_d;
      ula_op_q <= ula_op_d;
    end
  end

  assign done0  = done0_q;
  assign done1  = done1_q;
  assign r0     = r0_q;
  assign r1     = r1_q;
  assign f0     = f0_q;
  assign f1     = f1_q;
  assign busy   = busy_q;
  assign ula_a  = ula_a_q;
  assign ula_b  = ula_b_q;
  assign ula_op = ula_op_q;

endmodule

// File: tb/tb_ula_arb.sv
// Testbench for ula_arb: a LAT=1 instance driven from a vector table with a
// scoreboard, plus a LAT=0 instance used for the opcode sweep.
module tb_ula_arb;

  logic clk = 1'b0;
  logic clr;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference ULA: returns {flag, s}.
  function automatic logic [8:0] ula_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] op);
    logic [8:0] t;
    case (op)
      3'd0: t = {1'b0, a} + {1'b0, b};
      3'd1: t = {1'b0, a} - {1'b0, b};
      3'd2: t = {1'b0, a & b};
      3'd3: t = {1'b0, a | b};
      3'd4: t = {1'b0, a ^ b};
      3'd5: t = {1'b0, ~a};
      3'd6: t = {a[7], a[6:0], 1'b0};
      default: t = {a[0], 1'b0, a[7:1]};
    endcase
    if (op >= 3'd2 && op <= 3'd5) t[8] = (t[7:0] == 8'h00);
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- LAT=1 instance ----------------
  logic       req0, req1, done0, done1, f0, f1, busy, ula_flag;
  logic [7:0] a0, b0, a1, b1, r0, r1, ula_a, ula_b, ula_s;
  logic [2:0] op0, op1, ula_op;

  ula_arb #(.W(8), .LAT(1)) u1 (
    .clk(clk), .clr(clr),
    .req0(req0), .a0(a0), .b0(b0), .op0(op0),
    .req1(req1), .a1(a1), .b1(b1), .op1(op1),
    .done0(done0), .done1(done1), .r0(r0), .r1(r1), .f0(f0), .f1(f1),
    .busy(busy), .ula_a(ula_a), .ula_b(ula_b), .ula_op(ula_op),
    .ula_s(ula_s), .ula_flag(ula_flag)
  );

  // One-cycle-latency ULA: samples operands at the edge ending ISSUE.
  always @(posedge clk) {ula_flag, ula_s} <= ula_fn(ula_a, ula_b, ula_op);

  // ---------------- LAT=0 instance ----------------
  logic       xreq0, xreq1, xdone0, xdone1, xf0, xf1, xbusy, xula_flag;
  logic [7:0] xa0, xb0, xa1, xb1, xr0, xr1, xula_a, xula_b, xula_s;
  logic [2:0] xop0, xop1, xula_op;

  ula_arb #(.W(8), .LAT(0)) u0 (
    .clk(clk), .clr(clr),
    .req0(xreq0), .a0(xa0), .b0(xb0), .op0(xop0),
    .req1(xreq1), .a1(xa1), .b1(xb1), .op1(xop1),
    .done0(xdone0), .done1(xdone1), .r0(xr0), .r1(xr1), .f0(xf0), .f1(xf1),
    .busy(xbusy), .ula_a(xula_a), .ula_b(xula_b), .ula_op(xula_op),
    .ula_s(xula_s), .ula_flag(xula_flag)
  );

  assign {xula_flag, xula_s} = ula_fn(xula_a, xula_b, xula_op);

  // ---------------- scoreboard ----------------
  typedef struct {
    logic       id;
    logic [7:0] a, b;
    logic [2:0] op;
    logic [7:0] r;
    logic       f;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic       busy_prev = 1'b0;
  logic [7:0] m_r0 = '0, m_r1 = '0;
  logic       m_f0 = 1'b0, m_f1 = 1'b0;

  task automatic push(input logic id, input logic [7:0] a, input logic [7:0] b,
                      input logic [2:0] op);
    exp_t e;
    logic [8:0] t;
    t    = ula_fn(a, b, op);
    e.id = id; e.a = a; e.b = b; e.op = op; e.r = t[7:0]; e.f = t[8];
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!clr) begin
      if (busy && !busy_prev) begin
        if (sb.size() == 0) chk("issue_unexpected", 1, 0);
        else begin
          chk("ula_a", ula_a, sb[0].a);
          chk("ula_b", ula_b, sb[0].b);
          chk("ula_op", ula_op, sb[0].op);
        end
      end
      if (done0 && done1) chk("done_both", 1, 0);
      else if (done0 || done1) begin
        if (sb.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          mon_e = sb.pop_front();
          chk("done_id", done1, mon_e.id);
          if (mon_e.id) begin m_r1 = mon_e.r; m_f1 = mon_e.f; end
          else          begin m_r0 = mon_e.r; m_f0 = mon_e.f; end
          chk("r0", r0, m_r0);
          chk("f0", f0, m_f0);
          chk("r1", r1, m_r1);
          chk("f1", f1, m_f1);
        end
      end
    end
    busy_prev <= busy;
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic       rq0, rq1;
    logic [7:0] a0, b0;
    logic [2:0] op0;
    logic [7:0] a1, b1;
    logic [2:0] op1;
    logic       first;   // expected first winner
  } vec_t;

  vec_t vt[6];

  // Called at posedge+#1; the following cycle is the IDLE grant cycle.
  task automatic run_vec(input vec_t v);
    int k, td0, td1;
    logic p0, p1;
    if (v.rq0 && v.rq1) begin
      if (!v.first) begin push(0, v.a0, v.b0, v.op0); push(1, v.a1, v.b1, v.op1); end
      else          begin push(1, v.a1, v.b1, v.op1); push(0, v.a0, v.b0, v.op0); end
    end else if (v.rq0) push(0, v.a0, v.b0, v.op0);
    else                push(1, v.a1, v.b1, v.op1);
    a0 = v.a0; b0 = v.b0; op0 = v.op0;
    a1 = v.a1; b1 = v.b1; op1 = v.op1;
    req0 = v.rq0; req1 = v.rq1;
    k = cyc; td0 = -1; td1 = -1; p0 = v.rq0; p1 = v.rq1;
    for (int i = 0; i < 30 && (p0 || p1); i++) begin
      @(negedge clk);
      if (p0 && done0) begin td0 = cyc - k; p0 = 1'b0; end
      if (p1 && done1) begin td1 = cyc - k; p1 = 1'b0; end
      @(posedge clk); #1;
      if (!p0) req0 = 1'b0;
      if (!p1) req1 = 1'b0;
    end
    chk("done_timeout", {p0, p1}, 2'b00);
    if (v.rq0 && v.rq1) begin
      chk("lat_first",  v.first ? td1 : td0, 3);
      chk("lat_second", v.first ? td0 : td1, 7);
    end else begin
      chk("lat_single", v.rq0 ? td0 : td1, 3);
    end
  endtask

  task automatic do_reset();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    sb.delete();
    m_r0 = '0; m_r1 = '0; m_f0 = 1'b0; m_f1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t v;
    logic [8:0] t;
    int k, td;
    logic pend;

    clr = 1'b1;
    {req0, req1, a0, b0, op0, a1, b1, op1} = '0;
    {xreq0, xreq1, xa0, xb0, xop0, xa1, xb1, xop1} = '0;

    vt[0] = '{1'b1, 1'b1, 8'hF0, 8'h20, 3'd0, 8'h55, 8'h0F, 3'd2, 1'b0};
    vt[1] = '{1'b1, 1'b1, 8'h13, 8'h07, 3'd1, 8'h81, 8'h00, 3'd6, 1'b0};
    vt[2] = '{1'b1, 1'b0, 8'h3C, 8'hC3, 3'd4, 8'h00, 8'h00, 3'd0, 1'b0};
    vt[3] = '{1'b1, 1'b1, 8'h00, 8'h00, 3'd3, 8'h9A, 8'h00, 3'd7, 1'b1};
    vt[4] = '{1'b0, 1'b1, 8'h00, 8'h00, 3'd0, 8'hFF, 8'h00, 3'd5, 1'b1};
    vt[5] = '{1'b1, 1'b1, 8'h80, 8'h80, 3'd0, 8'h01, 8'h02, 3'd1, 1'b0};

    repeat (3) @(posedge clk);
    #1 clr = 1'b0;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_outputs", {done0, done1, r0, r1, f0, f1, busy, ula_a, ula_b, ula_op}, '0);
      chk("idle_outputs_lat0", {xdone0, xdone1, xr0, xr1, xf0, xf1, xbusy, xula_a, xula_b, xula_op}, '0);
    end
    @(posedge clk); #1;

    // Client 0 alone: 2B + 71 = 9C, no carry.
    v = '{1'b1, 1'b0, 8'h2B, 8'h71, 3'd0, 8'h00, 8'h00, 3'd0, 1'b0};
    run_vec(v);
    chk("r0_add", r0, 8'h9C);
    chk("f0_add", f0, 1'b0);
    chk("r1_untouched", r1, 8'h00);
    chk("f1_untouched", f1, 1'b0);

    do_reset();
    for (int i = 0; i < 6; i++) run_vec(vt[i]);

    // Abandon a client 1 operation with clr during WAIT.
    push(1, 8'h77, 8'h11, 3'd4);
    a1 = 8'h77; b1 = 8'h11; op1 = 3'd4; req1 = 1'b1;
    @(posedge clk); #1;           // ISSUE
    @(posedge clk); #1;           // WAIT
    clr = 1'b1; req1 = 1'b0;
    @(posedge clk); #1;
    clr = 1'b0;
    sb.delete();
    m_r0 = '0; m_r1 = '0; m_f0 = 1'b0; m_f1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_done1_after_clr", done1, 1'b0);
      chk("busy_after_clr", busy, 1'b0);
    end
    chk("r1_after_clr", r1, 8'h00);
    chk("f1_after_clr", f1, 1'b0);
    @(posedge clk); #1;
    v = '{1'b1, 1'b1, 8'h11, 8'h22, 3'd0, 8'h33, 8'h44, 3'd3, 1'b0};
    run_vec(v);

    // LAT=0: sweep all opcodes on client 1.
    for (int unsigned o = 0; o < 8; o++) begin
      xa1 = 8'h5A ^ 8'(o * 37);
      xb1 = 8'hA3 + 8'(o);
      xop1 = 3'(o);
      t = ula_fn(xa1, xb1, xop1);
      xreq1 = 1'b1;
      k = cyc; td = -1; pend = 1'b1;
      for (int i = 0; i < 20 && pend; i++) begin
        @(negedge clk);
        if (xdone1) begin td = cyc - k; pend = 1'b0; end
        @(posedge clk); #1;
        if (!pend) xreq1 = 1'b0;
      end
      chk("x_done_timeout", pend, 1'b0);
      chk("x_lat", td, 2);
      chk("x_r1", xr1, t[7:0]);
      chk("x_f1", xf1, t[8]);
      chk("x_r0_untouched", xr0, 8'h00);
    end

    repeat (2) @(posedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
